tc_stack_ctrl: RTL and testbench
================================

// Module: tc_stack_ctrl
// PURPOSE
//   LIFO stack controller in front of the 256x8 TC RAM. Turns push/pop requests into
//   registered load/save/address/in strobes for the RAM, and returns popped bytes.
//   Tracks the stack pointer, full and empty state, and sticky error flags.
//   Sits between the CPU datapath (upstream) and the RAM instance (downstream).
// PARAMETERS
//   ADDR_W  8    RAM address width
//   DATA_W  8    data width
//   DEPTH   256  stack entries; DEPTH <= 2**ADDR_W, DEPTH >= 2
//   BASE    0    RAM address of stack slot 0; BASE+DEPTH-1 <= 2**ADDR_W-1
// PORTS
//   clk            in   1         clock, rising-edge logic
//   rst            in   1         reset, asynchronous, active-high
//   push           in   1         push request; sampled when ready=1
//   pop            in   1         pop request; sampled when ready=1
//   push_data      in   DATA_W    byte to push
//   ready          out  1         controller accepts a request this cycle
//   pop_valid      out  1         one-cycle pulse; pop_data holds the popped byte
//   pop_data       out  DATA_W    popped byte; held until the next pop completes
//   count          out  ADDR_W+1  number of entries on the stack
//   full           out  1         count == DEPTH
//   empty          out  1         count == 0
//   err_overflow   out  1         sticky: a push arrived while full
//   err_underflow  out  1         sticky: a pop arrived while empty
//   err_conflict   out  1         sticky: push and pop arrived in the same cycle
//   ram_load       out  1         to RAM load
//   ram_save       out  1         to RAM save
//   ram_address    out  ADDR_W    to RAM address
//   ram_in         out  DATA_W    to RAM in
//   ram_out        in   DATA_W    from RAM out; valid in the cycle after ram_load=1
// BEHAVIOUR
//   Reset (async):
//     - All outputs are 0, except ready=1 and empty=1.
//     - State goes to IDLE and sp/count go to 0.
//     - RAM contents are not cleared; stale data above sp is never returned.
//   All ram_* outputs are flops. ram_load=1 and ram_save=1 are never asserted together.
//   States: IDLE, RD_ISSUE, RD_WAIT, RD_DONE. ready = (state == IDLE).
//   Push (IDLE, push=1, pop=0, !full), accepted in cycle N:
//     - In N+1: ram_save=1, ram_address=BASE+count, ram_in=push_data.
//     - count increments at the end of N. State stays IDLE, so back-to-back pushes
//       run at 1 per cycle.
//   Pop (IDLE, pop=1, push=0, !empty), accepted in cycle N:
//     - count decrements at the end of N. Go to RD_ISSUE.
//     - N+1 (RD_ISSUE): ram_load=1, ram_address=BASE+new count.
//     - N+2 (RD_WAIT): capture ram_out into pop_data at the end of the cycle.
//     - N+3 (RD_DONE): pop_valid=1, then return to IDLE.
//     - Latency from pop acceptance to pop_valid is 3 cycles. ready=0 during N+1..N+3.
//   Push immediately after a pop-complete, or pop immediately after a push:
//     - The RAM writes on the falling edge of the save cycle, so a pop accepted in the
//       cycle after a push reads the new value. No bypass is needed.
//   Boundaries:
//     - Push while full: no RAM write, count unchanged, err_overflow set.
//     - Pop while empty: no ram_load, no pop_valid, err_underflow set.
//     - push && pop in the same cycle: push is performed as above, pop is dropped,
//       err_conflict set. If also full, nothing happens; err_overflow and err_conflict
//       are both set.
//     - Requests with ready=0 are ignored with no error.
//     - count never wraps: it is bounded 0..DEPTH.
//     - Error flags clear only on rst.
//   Reset mid-pop: the read is abandoned immediately, pop_valid is not issued, and
//   ram_load drops asynchronously.
// STRUCTURE
//   - Package tc_stack_pkg: state enum (IDLE, RD_ISSUE, RD_WAIT, RD_DONE) and a
//     localparam function for the count width.
//   - Single flat module, no sub-modules.
//   - The pointer/count logic is small enough to stay inline.
// TESTING
//   1. Push 0x11, 0x22, 0x33 in three consecutive cycles ->
//      ram_save pulses at addresses 0, 1, 2 with matching ram_in; count=3.
//   2. Pop three times after scenario 1 ->
//      pop_data 0x33, 0x22, 0x11; each pop_valid 3 cycles after acceptance;
//      ready=0 during each read; empty=1 at the end.
//   3. Push 256 bytes, then push 0xAA ->
//      full=1, no ram_save for 0xAA, err_overflow=1, count=256.
//   4. Pop while empty ->
//      no ram_load, no pop_valid, err_underflow=1, count=0.
//   5. Push 0x5A and pop in the same cycle with count=1 ->
//      count=2, ram_save at address 1, no read, err_conflict=1.
//   6. Assert rst during RD_WAIT ->
//      ram_load=0 and pop_valid=0 immediately; after release ready=1, count=0;
//      pop_valid never pulses.

Source files
------------

// File: rtl/tc_stack_pkg.sv
// Shared types for the TC stack controller: read-sequence states and count sizing.
package tc_stack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DONE  = 2'd3
  } state_t;

  // count must hold 0..DEPTH inclusive, and DEPTH can equal 2**ADDR_W
  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/tc_stack_ctrl.sv
// LIFO stack controller in front of the TC RAM: turns push/pop requests into
// registered RAM strobes, tracks the stack pointer and sticky error flags.
module tc_stack_ctrl
  import tc_stack_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            push_data,
  output logic                         ready,
  output logic                         pop_valid,
  output logic [DATA_W-1:0]            pop_data,
  output logic [count_width(ADDR_W)-1:0] count,
  output logic                         full,
  output logic                         empty,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_conflict,
  output logic                         ram_load,
  output logic                         ram_save,
  output logic [ADDR_W-1:0]            ram_address,
  output logic [DATA_W-1:0]            ram_in,
  input  logic [DATA_W-1:0]            ram_out
);

  localparam int CW = count_width(ADDR_W);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                ram_load_reg, ram_load_next;
  logic                ram_save_reg, ram_save_next;
  logic [ADDR_W-1:0]   ram_address_reg, ram_address_next;
  logic [DATA_W-1:0]   ram_in_reg, ram_in_next;
  logic                pop_valid_reg, pop_valid_next;
  logic [DATA_W-1:0]   pop_data_reg, pop_data_next;
  logic                err_overflow_reg, err_overflow_next;
  logic                err_underflow_reg, err_underflow_next;
  logic                err_conflict_reg, err_conflict_next;
  logic                full_w, empty_w;

  assign full_w  = (count_reg == DEPTH_C);
  assign empty_w = (count_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      count_reg         <= '0;
      ram_load_reg      <= 1'b0;
      ram_save_reg      <= 1'b0;
      ram_address_reg   <= '0;
      ram_in_reg        <= '0;
      pop_valid_reg     <= 1'b0;
      pop_data_reg      <= '0;
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
      err_conflict_reg  <= 1'b0;
    end else begin
      state_reg         <= state_next;
      count_reg         <= count_next;
      ram_load_reg      <= ram_load_next;
      ram_save_reg      <= ram_save_next;
      ram_address_reg   <= ram_address_next;
      ram_in_reg        <= ram_in_next;
      pop_valid_reg     <= pop_valid_next;
      pop_data_reg      <= pop_data_next;
      err_overflow_reg  <= err_overflow_next;
      err_underflow_reg <= err_underflow_next;
      err_conflict_reg  <= err_conflict_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    count_next         = count_reg;
    ram_load_next      = 1'b0;
    ram_save_next      = 1'b0;
    ram_address_next   = ram_address_reg;
    ram_in_next        = ram_in_reg;
    pop_valid_next     = 1'b0;
    pop_data_next      = pop_data_reg;
    err_overflow_next  = err_overflow_reg;
    err_underflow_next = err_underflow_reg;
    err_conflict_next  = err_conflict_reg;

    unique case (state_reg)
      IDLE: begin
        // push wins a simultaneous request; the pop is dropped and flagged
        if (push) begin
          if (pop) err_conflict_next = 1'b1;
          if (full_w) begin
            err_overflow_next = 1'b1;
          end else begin
            ram_save_next    = 1'b1;
            ram_address_next = BASE_A + count_reg[ADDR_W-1:0];
            ram_in_next      = push_data;
            count_next       = count_reg + CW'(1);
          end
        end else if (pop) begin
          if (empty_w) begin
            err_underflow_next = 1'b1;
          end else begin
            count_next       = count_reg - CW'(1);
            ram_load_next    = 1'b1;
            ram_address_next = BASE_A + count_next[ADDR_W-1:0];
            state_next       = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        pop_data_next  = ram_out;
        pop_valid_next = 1'b1;
        state_next     = RD_DONE;
      end
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready         = (state_reg == IDLE);
  assign pop_valid     = pop_valid_reg;
  assign pop_data      = pop_data_reg;
  assign count         = count_reg;
  assign full          = full_w;
  assign empty         = empty_w;
  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;
  assign err_conflict  = err_conflict_reg;
  assign ram_load      = ram_load_reg;
  assign ram_save      = ram_save_reg;
  assign ram_address   = ram_address_reg;
  assign ram_in        = ram_in_reg;

endmodule

// File: tb/tb_tc_stack_ctrl.sv
// Directed bench for tc_stack_ctrl with a behavioural 256x8 RAM (write on falling
// edge of the save cycle, read data valid the cycle after load).
module tb_tc_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       ready, pop_valid, full, empty;
  logic [7:0] pop_data;
  logic [8:0] count;
  logic       err_overflow, err_underflow, err_conflict;
  logic       ram_load, ram_save;
  logic [7:0] ram_address, ram_in;
  logic [7:0] ram_out = 8'h00;

  int errors = 0;
  int checks = 0;
  int both_strobes = 0;
  int pv_seen = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  tc_stack_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .BASE(0)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .ready(ready), .pop_valid(pop_valid), .pop_data(pop_data), .count(count),
    .full(full), .empty(empty), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_conflict(err_conflict),
    .ram_load(ram_load), .ram_save(ram_save), .ram_address(ram_address),
    .ram_in(ram_in), .ram_out(ram_out)
  );

  always @(negedge clk) if (ram_save) mem[ram_address] <= ram_in;
  always @(posedge clk) if (ram_load) ram_out <= mem[ram_address];
  always @(negedge clk) if (ram_load && ram_save) both_strobes++;
  always @(posedge clk) if (pop_valid) pv_seen++;

  typedef struct {
    logic       push, pop;
    logic [7:0] din;
    logic       rdy, save, load;
    logic [7:0] addr, rin;
    logic [8:0] cnt;
    logic       full, empty, pv;
    logic [7:0] pd;
    logic       eo, eu, ec;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(input logic pu, po, input logic [7:0] d,
                              input logic r, s, l, input logic [7:0] a, ri,
                              input logic [8:0] c, input logic f, e, pv,
                              input logic [7:0] pd, input logic eo, eu, ec);
    vec_t v;
    v.push = pu; v.pop = po; v.din = d; v.rdy = r; v.save = s; v.load = l;
    v.addr = a; v.rin = ri; v.cnt = c; v.full = f; v.empty = e; v.pv = pv;
    v.pd = pd; v.eo = eo; v.eu = eu; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; push_data = 8'h00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // push 11/22/33, pop them back with pop held high, underflow, conflict, pop 5A
    //         pu po din  rdy sv ld addr  rin   cnt  f e pv pd    eo eu ec
    vt[0]  = mk(1,0,8'h11, 1,1,0,8'h00,8'h11,9'd1,0,0,0,8'h00,0,0,0);
    vt[1]  = mk(1,0,8'h22, 1,1,0,8'h01,8'h22,9'd2,0,0,0,8'h00,0,0,0);
    vt[2]  = mk(1,0,8'h33, 1,1,0,8'h02,8'h33,9'd3,0,0,0,8'h00,0,0,0);
    vt[3]  = mk(0,1,8'h00, 0,0,1,8'h02,8'h33,9'd2,0,0,0,8'h00,0,0,0);
    vt[4]  = mk(0,1,8'h00, 0,0,0,8'h02,8'h33,9'd2,0,0,0,8'h00,0,0,0);
    vt[5]  = mk(0,1,8'h00, 0,0,0,8'h02,8'h33,9'd2,0,0,1,8'h33,0,0,0);
    vt[6]  = mk(0,1,8'h00, 1,0,0,8'h02,8'h33,9'd2,0,0,0,8'h33,0,0,0);
    vt[7]  = mk(0,1,8'h00, 0,0,1,8'h01,8'h33,9'd1,0,0,0,8'h33,0,0,0);
    vt[8]  = mk(0,1,8'h00, 0,0,0,8'h01,8'h33,9'd1,0,0,0,8'h33,0,0,0);
    vt[9]  = mk(0,1,8'h00, 0,0,0,8'h01,8'h33,9'd1,0,0,1,8'h22,0,0,0);
    vt[10] = mk(0,1,8'h00, 1,0,0,8'h01,8'h33,9'd1,0,0,0,8'h22,0,0,0);
    vt[11] = mk(0,1,8'h00, 0,0,1,8'h00,8'h33,9'd0,0,1,0,8'h22,0,0,0);
    vt[12] = mk(0,1,8'h00, 0,0,0,8'h00,8'h33,9'd0,0,1,0,8'h22,0,0,0);
    vt[13] = mk(0,0,8'h00, 0,0,0,8'h00,8'h33,9'd0,0,1,1,8'h11,0,0,0);
    vt[14] = mk(0,0,8'h00, 1,0,0,8'h00,8'h33,9'd0,0,1,0,8'h11,0,0,0);
    vt[15] = mk(0,1,8'h00, 1,0,0,8'h00,8'h33,9'd0,0,1,0,8'h11,0,1,0);
    vt[16] = mk(1,0,8'h77, 1,1,0,8'h00,8'h77,9'd1,0,0,0,8'h11,0,1,0);
    vt[17] = mk(1,1,8'h5A, 1,1,0,8'h01,8'h5A,9'd2,0,0,0,8'h11,0,1,1);
    vt[18] = mk(0,0,8'h00, 1,0,0,8'h01,8'h5A,9'd2,0,0,0,8'h11,0,1,1);
    vt[19] = mk(0,1,8'h00, 0,0,1,8'h01,8'h5A,9'd1,0,0,0,8'h11,0,1,1);
    vt[20] = mk(0,0,8'h00, 0,0,0,8'h01,8'h5A,9'd1,0,0,0,8'h11,0,1,1);
    vt[21] = mk(0,0,8'h00, 0,0,0,8'h01,8'h5A,9'd1,0,0,1,8'h5A,0,1,1);
    vt[22] = mk(0,0,8'h00, 1,0,0,8'h01,8'h5A,9'd1,0,0,0,8'h5A,0,1,1);
    vt[23] = mk(0,1,8'h00, 0,0,1,8'h00,8'h5A,9'd0,0,1,0,8'h5A,0,1,1);

    // reset values while rst is held
    #12;
    chk("rst_ready", ready, 1);   chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);   chk("rst_full", full, 0);
    chk("rst_load", ram_load, 0); chk("rst_save", ram_save, 0);
    chk("rst_pv", pop_valid, 0);  chk("rst_errs", {err_overflow, err_underflow, err_conflict}, 0);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      push = vt[i].push; pop = vt[i].pop; push_data = vt[i].din;
      cyc();
      $display("vec %0d: push=%0d pop=%0d din=%h -> rdy=%0d save=%0d load=%0d addr=%h cnt=%0d pv=%0d pd=%h",
               i, vt[i].push, vt[i].pop, vt[i].din, ready, ram_save, ram_load, ram_address, count, pop_valid, pop_data);
      chk($sformatf("v%0d_ready", i), ready, vt[i].rdy);
      chk($sformatf("v%0d_save", i), ram_save, vt[i].save);
      chk($sformatf("v%0d_load", i), ram_load, vt[i].load);
      chk($sformatf("v%0d_addr", i), ram_address, vt[i].addr);
      chk($sformatf("v%0d_rin", i), ram_in, vt[i].rin);
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      chk($sformatf("v%0d_flags", i), {full, empty}, {vt[i].full, vt[i].empty});
      chk($sformatf("v%0d_pv", i), pop_valid, vt[i].pv);
      chk($sformatf("v%0d_pd", i), pop_data, vt[i].pd);
      chk($sformatf("v%0d_errs", i), {err_overflow, err_underflow, err_conflict},
          {vt[i].eo, vt[i].eu, vt[i].ec});
    end

    // fill to DEPTH, then overflow and full+conflict
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push = 1'b1; push_data = 8'(i);
      cyc();
      chk("fill_addr", ram_address, 32'(i[7:0]));
      chk("fill_save", ram_save, 1);
    end
    $display("fill: count=%0d full=%0d", count, full);
    chk("fill_count", count, 256);
    chk("fill_full", full, 1);
    push_data = 8'hAA;
    cyc();
    $display("overflow push AA: save=%0d count=%0d eo=%0d", ram_save, count, err_overflow);
    chk("ovf_save", ram_save, 0);
    chk("ovf_count", count, 256);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_conflict", err_conflict, 0);
    pop = 1'b1;
    cyc();
    $display("full push+pop: save=%0d load=%0d count=%0d eo=%0d ec=%0d",
             ram_save, ram_load, count, err_overflow, err_conflict);
    chk("fullconf_save", ram_save, 0);
    chk("fullconf_load", ram_load, 0);
    chk("fullconf_count", count, 256);
    chk("fullconf_ec", err_conflict, 1);
    push = 1'b0;
    cyc();
    chk("top_load", ram_load, 1);
    chk("top_addr", ram_address, 8'hFF);
    pop = 1'b0;
    cyc(); cyc();
    $display("pop top: pv=%0d pd=%h count=%0d", pop_valid, pop_data, count);
    chk("top_pv", pop_valid, 1);
    chk("top_pd", pop_data, 8'hFF);
    chk("top_count", count, 255);

    // reset during RD_WAIT
    do_reset();
    push = 1'b1; push_data = 8'h42;
    cyc();
    push = 1'b0; pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("rw_in_issue", ram_load, 1);
    cyc();
    pv_seen = 0;
    #2 rst = 1'b1;
    #1;
    $display("reset in RD_WAIT: load=%0d pv=%0d ready=%0d count=%0d", ram_load, pop_valid, ready, count);
    chk("rw_load", ram_load, 0);
    chk("rw_pv", pop_valid, 0);
    chk("rw_ready", ready, 1);
    chk("rw_count", count, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("rw_no_pv", pv_seen, 0);
    chk("rw_after_ready", ready, 1);
    chk("rw_after_count", count, 0);

    // reset during RD_ISSUE drops ram_load mid-cycle
    push = 1'b1; push_data = 8'h24;
    cyc();
    push = 1'b0; pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("ri_load_before", ram_load, 1);
    #2 rst = 1'b1;
    #1;
    $display("reset in RD_ISSUE: load=%0d ready=%0d", ram_load, ready);
    chk("ri_load", ram_load, 0);
    chk("ri_ready", ready, 1);
    pv_seen = 0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("ri_no_pv", pv_seen, 0);

    chk("no_load_save_overlap", both_strobes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
